rom_burst_arbiter: RTL

- Shares the single 16K x 8 synchronous boot/BIOS ROM between two requesters: master 0 (CPU fetch path) and master 1 (copy/shadow engine).
- Each requester asks for a burst of 1..16 sequential bytes.
- The block arbitrates round-robin, sequences the ROM enable and address one beat per cycle, and returns data with per-master valid and done strobes.
- The ROM's one-cycle registered read latency is absorbed here.

---
 rtl/rom_burst_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rom_burst_arbiter.sv
// rom_burst_arbiter
//   Shares one synchronous ROM (registered read, one-cycle latency) between
//   two burst requesters. Requests are arbitrated round-robin in the IDLE
//   state. The winner's burst is then issued one beat per cycle, with the
//   address wrapping modulo 2^ADDR_W. Read data comes back with per-master
//   valid and done strobes.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   mX_req_i/addr_i/len_i        burst request, start address, beats-1
//   mX_gnt_o                     one-cycle pulse when the burst is accepted
//   mX_rvalid_o, mX_done_o       read data valid / last beat of the burst
//   rdata_o                      shared read data (ROM output passed through)
//   rom_en_o, rom_addr_o         ROM read enable and address
//   rom_dout_i                   ROM data, valid the cycle after rom_en_o
//   mX_abort_i                   owner abort (only with ROM_ARB_ABORT_EN)
//
// Build option
//   ROM_ARB_ABORT_EN : adds m0_abort_i/m1_abort_i. An abort from the owner
//                      during BURST ends the burst after the current beat.
module rom_burst_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LEN_W-1:0]  m0_len_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic              m0_done_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LEN_W-1:0]  m1_len_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic              m1_done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_dout_i
`ifdef ROM_ARB_ABORT_EN
  ,
  input  logic              m0_abort_i,
  input  logic              m1_abort_i
`endif
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               owner_p0, owner_d;   // 0 = m0, 1 = m1
  logic               ptr_q, ptr_d;        // preferred master on a tie
  logic [ADDR_W-1:0]  addr_p0, addr_d;
  logic [LEN_W-1:0]   rem_p0, rem_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               win;
  logic               issue_p0;
  logic               last_beat_p0;
  logic               abort_own;
  logic               vld0_p1, vld1_p1, done0_p1, done1_p1;

`ifdef ROM_ARB_ABORT_EN
  assign abort_own = owner_p0 ? m1_abort_i : m0_abort_i;
`else
  assign abort_own = 1'b0;
`endif

  // A beat is issued on every BURST cycle, so the ROM enable is simply the state.
  assign issue_p0 = (state_q == BURST);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_p0;
    ptr_d        = ptr_q;
    addr_d       = addr_p0;
    rem_d        = rem_p0;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    win          = 1'b0;
    last_beat_p0 = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          win     = (m0_req_i && m1_req_i) ? ptr_q : m1_req_i;
          state_d = BURST;
          owner_d = win;
          addr_d  = win ? m1_addr_i : m0_addr_i;
          rem_d   = win ? m1_len_i  : m0_len_i;
          gnt0_d  = ~win;
          gnt1_d  = win;
        end
      end
      BURST: begin
        last_beat_p0 = (rem_p0 == '0) || abort_own;
        if (last_beat_p0) begin
          // The finishing master yields the tie to the other one.
          state_d = IDLE;
          ptr_d   = ~owner_p0;
        end else begin
          addr_d = addr_p0 + ADDR_W'(1);
          rem_d  = rem_p0 - LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: issue (state, address, remaining beats) ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_p0 <= 1'b0;
      ptr_q    <= 1'b0;
      addr_p0  <= '0;
      rem_p0   <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_p0 <= owner_d;
      ptr_q    <= ptr_d;
      addr_p0  <= addr_d;
      rem_p0   <= rem_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
    end
  end

  // ---- stage p1: ROM read return ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld0_p1  <= 1'b0;
      vld1_p1  <= 1'b0;
      done0_p1 <= 1'b0;
      done1_p1 <= 1'b0;
    end else begin
      vld0_p1  <= issue_p0 && !owner_p0;
      vld1_p1  <= issue_p0 &&  owner_p0;
      done0_p1 <= issue_p0 && !owner_p0 && last_beat_p0;
      done1_p1 <= issue_p0 &&  owner_p0 && last_beat_p0;
    end
  end

  assign m0_gnt_o    = gnt0_q;
  assign m1_gnt_o    = gnt1_q;
  assign m0_rvalid_o = vld0_p1;
  assign m1_rvalid_o = vld1_p1;
  assign m0_done_o   = done0_p1;
  assign m1_done_o   = done1_p1;
  assign rom_en_o    = issue_p0;
  assign rom_addr_o  = addr_p0;
  assign rdata_o     = rom_dout_i;

endmodule
